// File: rtl/rand_pos_spread_pkg.sv
// Shared types and helpers for the random position spreader.
// Holds the FSM encoding, LFSR constants, and the squared-distance helper.
package rand_pos_spread_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_EXCL   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REJECT = 3'd4,
        ST_ACCEPT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] SEED_X_RST = 16'hACE1;
    localparam logic [15:0] SEED_Y_RST = 16'h1926;
    localparam logic [15:0] SEED_Y_MIX = 16'hA5A5;

    // Widest coordinate delta the distance helper accepts
    localparam int DW = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[14:0], ^(r & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so it is nudged to 1
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [2*DW:0] dist_sq(input logic [DW-1:0] dx,
                                              input logic [DW-1:0] dy);
        logic [2*DW:0] ex;
        logic [2*DW:0] ey;
        ex = {{(DW+1){1'b0}}, dx};
        ey = {{(DW+1){1'b0}}, dy};
        return ex * ex + ey * ey;
    endfunction

endpackage

// File: rtl/rand_pos_spread_pos_dist_check.sv
// Purpose: flags two points closer than a threshold (squared Euclidean compare).
// Latency: 1 cycle, result registered.
// Backpressure: none, evaluates a new operand pair every cycle.
module pos_dist_check
    import rand_pos_spread_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [CW-1:0] a_x,
    input  logic [CW-1:0] a_y,
    input  logic [CW-1:0] b_x,
    input  logic [CW-1:0] b_y,
    input  logic [CW-1:0] thr,
    output logic          conflict
);

    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [2*DW:0] d_sq;
    logic [2*DW:0] t_sq;

    always_comb begin
        dx   = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
        dy   = (a_y >= b_y) ? (a_y - b_y) : (b_y - a_y);
        d_sq = dist_sq(DW'(dx), DW'(dy));
        t_sq = dist_sq(DW'(thr), '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            conflict <= 1'b0;
        end else begin
            conflict <= (d_sq < t_sq);
        end
    end

endmodule

// File: rtl/rand_pos_spread.sv
// Purpose: draws up to MAX_NUM spaced random positions avoiding a keep-out point.
// Latency: first slot accepted 4 cycles after start; slot k costs at least 3+k cycles.
// Backpressure: start is ignored while busy; lists only change while busy.
module rand_pos_spread
    import rand_pos_spread_pkg::*;
#(
    parameter int MAX_NUM   = 9,
    parameter int CW        = 10,
    parameter int X_RANGE   = 320,
    parameter int Y_RANGE   = 180,
    parameter int MARGIN    = 16,
    parameter int MIN_DIST  = 32,
    parameter int EXCL_DIST = 48,
    parameter int MAX_TRIES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [15:0]           i_seed,
    input  logic [3:0]            i_count,
    input  logic [CW-1:0]         i_excl_x,
    input  logic [CW-1:0]         i_excl_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fail,
    output logic [3:0]            o_valid_cnt,
    output logic [MAX_NUM*CW-1:0] o_list_x,
    output logic [MAX_NUM*CW-1:0] o_list_y
);

    localparam int X_SPAN = X_RANGE - 2 * MARGIN;
    localparam int Y_SPAN = Y_RANGE - 2 * MARGIN;

    state_t        state;
    logic [15:0]   lfsr_x;
    logic [15:0]   lfsr_y;
    logic [3:0]    count_q;
    logic [3:0]    count_clamp;
    logic [3:0]    idx;
    logic [3:0]    chk_sel;
    logic [7:0]    tries;
    logic [8:0]    tries_inc;
    logic [CW-1:0] excl_x_q;
    logic [CW-1:0] excl_y_q;
    logic [CW-1:0] cand_x;
    logic [CW-1:0] cand_y;
    logic [CW-1:0] cand_x_d;
    logic [CW-1:0] cand_y_d;
    logic [31:0]   prod_x;
    logic [31:0]   prod_y;
    logic [CW-1:0] list_x [MAX_NUM];
    logic [CW-1:0] list_y [MAX_NUM];

    logic [CW-1:0] chk_ax;
    logic [CW-1:0] chk_ay;
    logic [CW-1:0] chk_bx;
    logic [CW-1:0] chk_by;
    logic [CW-1:0] chk_thr;
    logic          chk_conflict;

    // Full-width product keeps r*SPAN>>16 strictly below SPAN
    always_comb begin
        prod_x      = 32'(lfsr_x) * 32'(X_SPAN);
        prod_y      = 32'(lfsr_y) * 32'(Y_SPAN);
        cand_x_d    = CW'(32'(MARGIN) + (prod_x >> 16));
        cand_y_d    = CW'(32'(MARGIN) + (prod_y >> 16));
        count_clamp = (i_count > 4'(MAX_NUM)) ? 4'(MAX_NUM) : i_count;
        tries_inc   = {1'b0, tries} + 9'd1;
    end

    // The checker result lands one state later: DRAW feeds the keep-out test
    // read in EXCL, EXCL feeds entry 0, and CHECK at idx feeds entry idx+1.
    always_comb begin
        chk_sel = (state == ST_EXCL) ? 4'd0 : (idx + 4'd1);
        if (state == ST_DRAW) begin
            chk_ax  = cand_x_d;
            chk_ay  = cand_y_d;
            chk_bx  = excl_x_q;
            chk_by  = excl_y_q;
            chk_thr = CW'(EXCL_DIST);
        end else begin
            chk_ax  = cand_x;
            chk_ay  = cand_y;
            chk_bx  = (chk_sel < 4'(MAX_NUM)) ? list_x[chk_sel] : '0;
            chk_by  = (chk_sel < 4'(MAX_NUM)) ? list_y[chk_sel] : '0;
            chk_thr = CW'(MIN_DIST);
        end
    end

    pos_dist_check #(
        .CW (CW)
    ) u_dist (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .a_x      (chk_ax),
        .a_y      (chk_ay),
        .b_x      (chk_bx),
        .b_y      (chk_by),
        .thr      (chk_thr),
        .conflict (chk_conflict)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            lfsr_x      <= SEED_X_RST;
            lfsr_y      <= SEED_Y_RST;
            count_q     <= '0;
            idx         <= '0;
            tries       <= '0;
            excl_x_q    <= '0;
            excl_y_q    <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_valid_cnt <= '0;
            for (int k = 0; k < MAX_NUM; k++) begin
                list_x[k] <= '0;
                list_y[k] <= '0;
            end
        end else begin
            lfsr_x <= lfsr_next(lfsr_x);
            lfsr_y <= lfsr_next(lfsr_y);
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        lfsr_x      <= seed_fix(i_seed);
                        lfsr_y      <= seed_fix(i_seed ^ SEED_Y_MIX);
                        count_q     <= count_clamp;
                        excl_x_q    <= i_excl_x;
                        excl_y_q    <= i_excl_y;
                        tries       <= '0;
                        o_fail      <= 1'b0;
                        o_valid_cnt <= '0;
                        o_busy      <= 1'b1;
                        for (int k = 0; k < MAX_NUM; k++) begin
                            list_x[k] <= '0;
                            list_y[k] <= '0;
                        end
                        state <= (count_clamp == 4'd0) ? ST_DONE : ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    cand_x <= cand_x_d;
                    cand_y <= cand_y_d;
                    idx    <= '0;
                    state  <= ST_EXCL;
                end
                ST_EXCL: begin
                    state <= chk_conflict ? ST_REJECT : ST_CHECK;
                end
                ST_CHECK: begin
                    if (idx == o_valid_cnt) begin
                        state <= ST_ACCEPT;
                    end else if (chk_conflict) begin
                        state <= ST_REJECT;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_REJECT: begin
                    tries <= tries_inc[7:0];
                    if (tries_inc == 9'(MAX_TRIES)) begin
                        o_fail <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_DRAW;
                    end
                end
                ST_ACCEPT: begin
                    list_x[o_valid_cnt] <= cand_x;
                    list_y[o_valid_cnt] <= cand_y;
                    o_valid_cnt         <= o_valid_cnt + 4'd1;
                    tries               <= '0;
                    state <= ((o_valid_cnt + 4'd1) == count_q) ? ST_DONE : ST_DRAW;
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < MAX_NUM; k++) begin : g_flat
        assign o_list_x[k*CW +: CW] = list_x[k];
        assign o_list_y[k*CW +: CW] = list_y[k];
    end

endmodule

// File: tb/tb_rand_pos_spread.sv
// Directed bench for rand_pos_spread: default instance plus a wide-spacing instance.
module tb_rand_pos_spread;
    import rand_pos_spread_pkg::*;

    localparam int CW = 10;
    localparam int N  = 9;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          start_f;
    logic [15:0]   i_seed;
    logic [3:0]    i_count;
    logic [CW-1:0] i_excl_x;
    logic [CW-1:0] i_excl_y;

    logic          busy, done, fail;
    logic [3:0]    vcnt;
    logic [N*CW-1:0] lx, ly;
    logic          busy_f, done_f, fail_f;
    logic [3:0]    vcnt_f;
    logic [N*CW-1:0] lx_f, ly_f;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    rand_pos_spread dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seed(i_seed),
        .i_count(i_count), .i_excl_x(i_excl_x), .i_excl_y(i_excl_y),
        .o_busy(busy), .o_done(done), .o_fail(fail), .o_valid_cnt(vcnt),
        .o_list_x(lx), .o_list_y(ly)
    );

    // Field [16,164)x[16,124) has diagonal^2 = 33058 < 200^2, so no second slot fits
    rand_pos_spread #(.MIN_DIST(200), .X_RANGE(180), .Y_RANGE(140)) dut_far (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start_f), .i_seed(i_seed),
        .i_count(i_count), .i_excl_x(i_excl_x), .i_excl_y(i_excl_y),
        .o_busy(busy_f), .o_done(done_f), .o_fail(fail_f), .o_valid_cnt(vcnt_f),
        .o_list_x(lx_f), .o_list_y(ly_f)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic start_run(input bit far, input logic [15:0] seed, input logic [3:0] cnt,
                             input logic [CW-1:0] ex, input logic [CW-1:0] ey);
        @(negedge i_clk);
        i_seed = seed; i_count = cnt; i_excl_x = ex; i_excl_y = ey;
        if (far) start_f = 1'b1; else i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; start_f = 1'b0;
    endtask

    task automatic wait_done(input bit far, input int max, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < max) begin
            @(posedge i_clk); #1;
            cyc++;
            hit = far ? done_f : done;
        end
        check("done_seen", hit, 1'b1);
    endtask

    function automatic int pair_viol(input logic [N*CW-1:0] xs, input logic [N*CW-1:0] ys,
                                     input int n, input int d);
        int v = 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++) begin
                int dx = int'(xs[i*CW +: CW]) - int'(xs[j*CW +: CW]);
                int dy = int'(ys[i*CW +: CW]) - int'(ys[j*CW +: CW]);
                if (dx*dx + dy*dy < d*d) v++;
            end
        return v;
    endfunction

    function automatic int excl_viol(input logic [N*CW-1:0] xs, input logic [N*CW-1:0] ys,
                                     input int n, input int ex, input int ey, input int d);
        int v = 0;
        for (int i = 0; i < n; i++) begin
            int dx = int'(xs[i*CW +: CW]) - ex;
            int dy = int'(ys[i*CW +: CW]) - ey;
            if (dx*dx + dy*dy < d*d) v++;
        end
        return v;
    endfunction

    function automatic int range_viol(input logic [N*CW-1:0] vs, input int n,
                                      input int lo, input int hi);
        int v = 0;
        for (int i = 0; i < n; i++)
            if (int'(vs[i*CW +: CW]) < lo || int'(vs[i*CW +: CW]) >= hi) v++;
        return v;
    endfunction

    initial begin
        int cyc;
        int seen;
        bit found;
        logic [N*CW-1:0] lx1, ly1, lx5, ly5;

        i_rst = 1'b1; i_start = 1'b0; start_f = 1'b0;
        i_seed = '0; i_count = '0; i_excl_x = '0; i_excl_y = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b0;

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_vcnt", vcnt, 4'd0);
        check("rst_lx", lx, '0);
        check("rst_ly", ly, '0);

        // Test 1: seed 1 -> first draw (16,111) clears the keep-out, accepted at cycle 4
        start_run(1'b0, 16'h0001, 4'd9, 10'd160, 10'd90);
        check("t1_busy", busy, 1'b1);
        repeat (3) @(posedge i_clk); #1;
        check("t1_vcnt_pre", vcnt, 4'd0);
        @(posedge i_clk); #1;
        check("t1_vcnt_first", vcnt, 4'd1);
        check("t1_x0", lx[CW-1:0], 10'd16);
        check("t1_y0", ly[CW-1:0], 10'd111);
        wait_done(1'b0, 5000, cyc);
        check("t1_vcnt", vcnt, 4'd9);
        check("t1_fail", fail, 1'b0);
        check("t1_pairs", pair_viol(lx, ly, 9, 32), 0);
        check("t1_excl", excl_viol(lx, ly, 9, 160, 90, 48), 0);
        check("t1_xrange", range_viol(lx, 9, 16, 304), 0);
        check("t1_yrange", range_viol(ly, 9, 16, 164), 0);
        lx1 = lx; ly1 = ly;
        @(posedge i_clk); #1;
        check("t1_idle", busy, 1'b0);

        // Test 2: count 0 -> done on the second edge after start, lists cleared
        @(negedge i_clk);
        i_seed = 16'h0042; i_count = 4'd0; i_start = 1'b1;
        @(posedge i_clk); #1;
        check("t2_done_early", done, 1'b0);
        check("t2_busy", busy, 1'b1);
        @(negedge i_clk); i_start = 1'b0;
        @(posedge i_clk); #1;
        check("t2_done", done, 1'b1);
        check("t2_busy_off", busy, 1'b0);
        check("t2_vcnt", vcnt, 4'd0);
        check("t2_fail", fail, 1'b0);
        check("t2_lx", lx, '0);
        check("t2_ly", ly, '0);
        @(posedge i_clk); #1;
        check("t2_done_pulse", done, 1'b0);

        // Test 3: count 15 clamps to 9 and replays the seed-1 layout
        start_run(1'b0, 16'h0001, 4'd15, 10'd160, 10'd90);
        wait_done(1'b0, 5000, cyc);
        check("t3_vcnt", vcnt, 4'd9);
        check("t3_lx_same", lx, lx1);
        check("t3_ly_same", ly, ly1);

        // Test 4: wide spacing -> one slot, then 255 rejects and failure
        start_run(1'b1, 16'h00FF, 4'd3, 10'd90, 10'd70);
        wait_done(1'b1, 5000, cyc);
        check("t4_fail", fail_f, 1'b1);
        check("t4_vcnt", vcnt_f, 4'd1);
        check("t4_min_time", cyc >= 765, 1'b1);
        check("t4_x0", range_viol(lx_f, 1, 16, 164), 0);
        check("t4_y0", range_viol(ly_f, 1, 16, 124), 0);
        check("t4_x_unused", lx_f[N*CW-1:CW], '0);
        start_run(1'b1, 16'h0000, 4'd0, 10'd0, 10'd0);
        check("t4_fail_cleared", fail_f, 1'b0);
        wait_done(1'b1, 10, cyc);

        // Test 5: determinism and start-while-busy ignored
        start_run(1'b0, 16'h1234, 4'd5, 10'd40, 10'd40);
        wait_done(1'b0, 5000, cyc);
        lx5 = lx; ly5 = ly;
        check("t5_vcnt_a", vcnt, 4'd5);
        start_run(1'b0, 16'h1234, 4'd5, 10'd40, 10'd40);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("t5_busy_mid", busy, 1'b1);
        i_seed = 16'hBEEF; i_count = 4'd2; i_excl_x = 10'd300; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        wait_done(1'b0, 5000, cyc);
        check("t5_vcnt_b", vcnt, 4'd5);
        check("t5_lx_same", lx, lx5);
        check("t5_ly_same", ly, ly5);
        seen = 0;
        repeat (5) begin
            @(posedge i_clk); #1;
            if (done || busy) seen++;
        end
        check("t5_no_restart", seen, 0);

        // Test 6: reset during CHECK with entries stored
        start_run(1'b0, 16'h0001, 4'd9, 10'd160, 10'd90);
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 3000) begin
            @(posedge i_clk); #1;
            cyc++;
            found = (dut.state == ST_CHECK) && (vcnt >= 4'd3);
        end
        check("t6_reached_check", found, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("t6_busy", busy, 1'b0);
        check("t6_vcnt", vcnt, 4'd0);
        check("t6_lx", lx, '0);
        check("t6_ly", ly, '0);
        check("t6_done", done, 1'b0);
        @(negedge i_clk); i_rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge i_clk); #1;
            if (done || busy) seen++;
        end
        check("t6_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
